// File: rtl/red_line_sequencer.sv
// red_line_sequencer
// Sequences the bank of 1-bit red-detection line buffers from camera timing.
// Produces the per-pixel write address, a one-hot write enable per buffer, the
// matching read address, the tap rotation select for the 3-tap column filter
// and a qualifier telling the filter when its taps hold complete lines.
//
// Ports
//   bit_clk     pixel clock, all logic on its rising edge
//   rst_n       synchronous active-low reset
//   v_sync      high during the active frame
//   h_sync      high during the active part of a line
//   pix_valid   pixel qualifier while h_sync is high
//   wr_addr     write address (pixel x position)
//   rd_addr     read address, same as wr_addr
//   wren        one-hot write enable, zero when not writing
//   tap_sel     index of the buffer being filled, aligned with wren
//   taps_valid  taps hold NUM_BUFFERS-1 complete lines of this frame
//   line_done   one-cycle pulse per completed line
//   line_count  completed lines in this frame, saturating
//   overflow    sticky: a line carried more than LINE_WIDTH pixels
//
// state | meaning
// IDLE  | outside the frame; h_sync activity ignored, x held at 0
// FILL  | frame active, fewer than NUM_BUFFERS-1 lines captured
// RUN   | frame active, taps hold enough complete lines for the filter
module red_line_sequencer #(
   parameter int NUM_BUFFERS = 4,
   parameter int PTR_W       = 2,
   parameter int ADDR_W      = 10,
   parameter int LINE_WIDTH  = 640
) (
   input  logic                   bit_clk,
   input  logic                   rst_n,
   input  logic                   v_sync,
   input  logic                   h_sync,
   input  logic                   pix_valid,
   output logic [ADDR_W-1:0]      wr_addr,
   output logic [ADDR_W-1:0]      rd_addr,
   output logic [NUM_BUFFERS-1:0] wren,
   output logic [PTR_W-1:0]       tap_sel,
   output logic                   taps_valid,
   output logic                   line_done,
   output logic [9:0]             line_count,
   output logic                   overflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   // x needs one extra bit so it can rest at LINE_WIDTH after a full line.
   localparam logic [ADDR_W:0]  X_END     = (ADDR_W+1)'(LINE_WIDTH);
   localparam logic [PTR_W-1:0] LF_LAST   = PTR_W'(NUM_BUFFERS - 1);
   localparam logic [PTR_W-1:0] LF_PREV   = PTR_W'(NUM_BUFFERS - 2);
   localparam logic [9:0]       COUNT_MAX = '1;

   state_t                 state, state_nxt;
   logic                   hs_d, vs_d;
   logic                   h_fall, v_rise, v_fall;
   logic                   active, do_write, do_line, do_start, set_ovf;
   logic [ADDR_W:0]        x;
   logic [PTR_W-1:0]       wr_ptr, lines_filled;
   logic [NUM_BUFFERS-1:0] wr_onehot;

   assign rd_addr = wr_addr;

   always_comb begin
      wr_onehot         = '0;
      wr_onehot[wr_ptr] = 1'b1;
   end

   always_ff @(posedge bit_clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // v_fall wins over everything else in the same cycle, including h_fall,
   // so an aborted line never advances the pointer or pulses line_done.
   always_comb begin
      h_fall    = ~h_sync & hs_d;
      v_rise    = v_sync & ~vs_d;
      v_fall    = ~v_sync & vs_d;
      state_nxt = state;
      do_start  = 1'b0;
      active    = (state == FILL) || (state == RUN);
      if (v_fall) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (v_rise) begin
               state_nxt = FILL;
               do_start  = 1'b1;
            end
            FILL: if (h_fall && (lines_filled == LF_PREV)) state_nxt = RUN;
            RUN:  state_nxt = RUN;
            default: state_nxt = IDLE;
         endcase
      end
      do_write = active & ~v_fall & h_sync & pix_valid & (x < X_END);
      set_ovf  = active & ~v_fall & h_sync & pix_valid & (x == X_END);
      do_line  = active & ~v_fall & h_fall;
   end

   always_ff @(posedge bit_clk) begin
      if (!rst_n) begin
         hs_d         <= 1'b0;
         vs_d         <= 1'b0;
         x            <= '0;
         wr_ptr       <= '0;
         lines_filled <= '0;
         wr_addr      <= '0;
         wren         <= '0;
         tap_sel      <= '0;
         taps_valid   <= 1'b0;
         line_done    <= 1'b0;
         line_count   <= '0;
         overflow     <= 1'b0;
      end else begin
         hs_d       <= h_sync;
         vs_d       <= v_sync;
         wren       <= do_write ? wr_onehot : '0;
         line_done  <= do_line;
         taps_valid <= (state == RUN) & h_sync & ~v_fall;
         tap_sel    <= wr_ptr;
         if (do_write) begin
            wr_addr <= x[ADDR_W-1:0];
            x       <= x + (ADDR_W+1)'(1);
         end
         if (set_ovf) overflow <= 1'b1;
         if (do_line) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            x      <= '0;
            if (lines_filled != LF_LAST) lines_filled <= lines_filled + PTR_W'(1);
            if (line_count != COUNT_MAX) line_count <= line_count + 10'd1;
         end
         if (do_start) begin
            wr_ptr       <= '0;
            lines_filled <= '0;
            line_count   <= '0;
            overflow     <= 1'b0;
         end
         if (state_nxt == IDLE) x <= '0;
      end
   end

endmodule

// File: tb/tb_red_line_sequencer.sv
// Testbench for red_line_sequencer: a short table of cycle vectors, directed
// multi-cycle sequences, and randomized frames, all compared cycle by cycle
// against a frame/line-count reference model.
module tb_red_line_sequencer;

   localparam int NB = 4;
   localparam int LW = 640;

   logic       bit_clk = 1'b0;
   logic       rst_n = 1'b0, v_sync = 1'b0, h_sync = 1'b0, pix_valid = 1'b0;
   logic [9:0] wr_addr, rd_addr, line_count;
   logic [3:0] wren;
   logic [1:0] tap_sel;
   logic       taps_valid, line_done, overflow;

   red_line_sequencer dut (
      .bit_clk(bit_clk), .rst_n(rst_n), .v_sync(v_sync), .h_sync(h_sync),
      .pix_valid(pix_valid), .wr_addr(wr_addr), .rd_addr(rd_addr), .wren(wren),
      .tap_sel(tap_sel), .taps_valid(taps_valid), .line_done(line_done),
      .line_count(line_count), .overflow(overflow)
   );

   always #5 bit_clk = ~bit_clk;

   int n_chk = 0, n_pass = 0, n_done = 0, cyc_n = 0;

   // reference model: frame flag, lines completed this frame, pixel position
   bit         m_act = 0, m_ovf = 0, m_ph = 0, m_pv = 0;
   int         m_lines = 0, m_x = 0;
   logic [3:0] e_wren = '0;
   bit         e_done = 0, e_tv = 0;
   logic [9:0] e_addr = '0;
   logic [1:0] e_tap = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc_n, act, exp);
   endtask

   task automatic model_step(input logic r, input logic v, input logic h, input logic p);
      bit vr, vf, hf;
      e_wren = '0; e_done = 0; e_tv = 0;
      if (!r) begin
         m_act = 0; m_lines = 0; m_x = 0; m_ovf = 0; m_ph = 0; m_pv = 0;
         return;
      end
      vr = v && !m_pv;
      vf = !v && m_pv;
      hf = !h && m_ph;
      m_ph = h; m_pv = v;
      if (vf) begin
         m_act = 0; m_x = 0;
      end else if (!m_act) begin
         if (vr) begin m_act = 1; m_lines = 0; m_x = 0; m_ovf = 0; end
      end else begin
         e_tv = h && (m_lines >= NB - 1);
         if (h && p) begin
            if (m_x < LW) begin
               e_wren = 4'(1 << (m_lines % NB));
               e_tap  = 2'(m_lines % NB);
               e_addr = 10'(m_x);
               m_x++;
            end else m_ovf = 1;
         end
         if (hf) begin m_lines++; m_x = 0; e_done = 1; end
      end
   endtask

   task automatic check_model();
      logic [9:0] ecnt;
      logic       w;
      ecnt = (m_lines > 1023) ? 10'd1023 : 10'(m_lines);
      w = (e_wren != 0);
      n_chk++;
      if ({wren, line_done, taps_valid, line_count, overflow,
           w ? wr_addr : 10'd0, w ? rd_addr : 10'd0, w ? tap_sel : 2'd0} ===
          {e_wren, e_done, e_tv, ecnt, m_ovf,
           w ? e_addr : 10'd0, w ? e_addr : 10'd0, w ? e_tap : 2'd0})
         n_pass++;
      else
         $display("FAIL model cyc=%0d got wren=%b done=%b tv=%b cnt=%0d ovf=%b addr=%0d rd=%0d tap=%0d required wren=%b done=%b tv=%b cnt=%0d ovf=%b addr=%0d tap=%0d",
                  cyc_n, wren, line_done, taps_valid, line_count, overflow, wr_addr, rd_addr, tap_sel,
                  e_wren, e_done, e_tv, ecnt, m_ovf, e_addr, e_tap);
   endtask

   task automatic cyc(input logic r, input logic v, input logic h, input logic p);
      rst_n = r; v_sync = v; h_sync = h; pix_valid = p;
      @(posedge bit_clk);
      model_step(r, v, h, p);
      #1;
      cyc_n++;
      if (line_done) n_done++;
      check_model();
   endtask

   task automatic run_line(input int npix, input bit gapped, output int nwr,
                           output logic [3:0] seen, output bit tv_any);
      int ncyc;
      nwr = 0; seen = '0; tv_any = 0;
      ncyc = gapped ? 2 * npix : npix;
      for (int i = 0; i < ncyc; i++) begin
         cyc(1'b1, 1'b1, 1'b1, gapped ? ((i % 2) == 0) : 1'b1);
         if (wren != 0) begin nwr++; seen |= wren; end
         if (taps_valid) tv_any = 1;
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   typedef struct {
      logic r, v, h, p;
      logic [3:0] wren;
      logic done, tv;
      logic [9:0] cnt;
      logic ovf;
      logic [9:0] addr;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic v, input logic h, input logic p,
                               input logic [3:0] w, input logic d, input logic t,
                               input int c, input logic o, input int a);
      vec_t x;
      x.r = r; x.v = v; x.h = h; x.p = p; x.wren = w; x.done = d; x.tv = t;
      x.cnt = 10'(c); x.ovf = o; x.addr = 10'(a);
      return x;
   endfunction

   initial begin
      vec_t       tbl[16];
      int         nwr, cnt, d0;
      logic [3:0] seen;
      bit         tv_any, abort_f;
      logic [3:0] exp_buf[6];

      tbl[0]  = mk(0,0,0,0, 4'b0000,0,0,0,0,0);
      tbl[1]  = mk(1,1,0,0, 4'b0000,0,0,0,0,0);
      tbl[2]  = mk(1,1,1,1, 4'b0001,0,0,0,0,0);
      tbl[3]  = mk(1,1,1,0, 4'b0000,0,0,0,0,0);
      tbl[4]  = mk(1,1,1,1, 4'b0001,0,0,0,0,1);
      tbl[5]  = mk(1,1,0,0, 4'b0000,1,0,1,0,0);
      tbl[6]  = mk(1,1,1,1, 4'b0010,0,0,1,0,0);
      tbl[7]  = mk(1,1,0,0, 4'b0000,1,0,2,0,0);
      tbl[8]  = mk(1,1,1,0, 4'b0000,0,0,2,0,0);
      tbl[9]  = mk(1,1,0,0, 4'b0000,1,0,3,0,0);
      tbl[10] = mk(1,1,1,1, 4'b1000,0,1,3,0,0);
      tbl[11] = mk(1,1,1,1, 4'b1000,0,1,3,0,1);
      tbl[12] = mk(1,0,1,1, 4'b0000,0,0,3,0,0);
      tbl[13] = mk(1,0,0,0, 4'b0000,0,0,3,0,0);
      tbl[14] = mk(1,1,0,0, 4'b0000,0,0,0,0,0);
      tbl[15] = mk(1,1,1,1, 4'b0001,0,0,0,0,0);
      exp_buf[0] = 4'b0001; exp_buf[1] = 4'b0010; exp_buf[2] = 4'b0100;
      exp_buf[3] = 4'b1000; exp_buf[4] = 4'b0001; exp_buf[5] = 4'b0010;

      for (int i = 0; i < 16; i++) begin
         cyc(tbl[i].r, tbl[i].v, tbl[i].h, tbl[i].p);
         chk($sformatf("vec%0d", i),
             {wren, line_done, taps_valid, line_count, overflow, (wren != 0) ? wr_addr : 10'd0},
             {tbl[i].wren, tbl[i].done, tbl[i].tv, tbl[i].cnt, tbl[i].ovf,
              (tbl[i].wren != 0) ? tbl[i].addr : 10'd0});
      end
      cyc(1, 1, 0, 0);

      // clean frame: six full lines, pointer wraps
      cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
      d0 = n_done;
      for (int l = 0; l < 6; l++) begin
         run_line(LW, 0, nwr, seen, tv_any);
         chk($sformatf("full_nwr%0d", l), 64'(nwr), 64'(LW));
         chk($sformatf("full_buf%0d", l), 64'(seen), 64'(exp_buf[l]));
         chk($sformatf("full_tv%0d", l), 64'(tv_any), 64'(l >= 3));
         if (l == 2) chk("count_after3", 64'(line_count), 64'd3);
      end
      chk("done_pulses6", 64'(n_done - d0), 64'd6);

      // overflow: 645 pixels, sticky, clears on next frame
      run_line(LW + 5, 0, nwr, seen, tv_any);
      chk("ovf_nwr", 64'(nwr), 64'(LW));
      chk("ovf_set", 64'(overflow), 64'd1);
      run_line(5, 0, nwr, seen, tv_any);
      chk("ovf_sticky", 64'(overflow), 64'd1);
      cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
      chk("ovf_clear", 64'({overflow, line_count}), 64'd0);

      // gapped pixels
      run_line(20, 1, nwr, seen, tv_any);
      chk("gap_nwr", 64'(nwr), 64'd20);
      chk("gap_buf", 64'(seen), 64'b0001);

      // v_fall at x=300 on line 2
      cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
      run_line(LW, 0, nwr, seen, tv_any);
      for (int i = 0; i < 300; i++) cyc(1, 1, 1, 1);
      cyc(1, 0, 1, 1);
      chk("vfall_quiet", 64'({wren, line_done, taps_valid}), 64'd0);
      cyc(1, 0, 0, 0);
      chk("vfall_no_done", 64'(line_done), 64'd0);
      cyc(1, 1, 0, 0);
      run_line(10, 0, nwr, seen, tv_any);
      chk("vfall_restart_buf", 64'(seen), 64'b0001);
      chk("vfall_restart_tv", 64'(tv_any), 64'd0);

      // reset at x=100
      for (int i = 0; i < 100; i++) cyc(1, 1, 1, 1);
      cyc(0, 1, 1, 1);
      chk("rst_outs", 64'({wren, wr_addr, rd_addr, tap_sel, taps_valid, line_done, line_count, overflow}), 64'd0);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1, 0, (i % 4) < 2, 1);
         if (wren != 0) cnt++;
      end
      chk("rst_no_wren", 64'(cnt), 64'd0);
      cyc(1, 1, 0, 0);
      run_line(8, 0, nwr, seen, tv_any);
      chk("rst_resume", 64'(nwr), 64'd8);

      // zero-pixel lines, line_count saturation
      for (int i = 0; i < 1030; i++) begin cyc(1, 1, 1, 0); cyc(1, 1, 0, 0); end
      chk("count_sat", 64'(line_count), 64'd1023);

      // randomized frames
      for (int f = 0; f < 4; f++) begin
         cyc(1, 0, 0, 0);
         cyc(1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         cyc(1, 0, 0, 0);
         cyc(1, 1, 0, 0);
         abort_f = 0;
         for (int l = 0; l < int'($urandom_range(1, 6)) && !abort_f; l++) begin
            int len, thr;
            bit ab;
            len = int'($urandom_range(0, 660));
            thr = int'($urandom_range(1, 4));
            ab  = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < len; i++) begin
               cyc(1, 1, 1, int'($urandom_range(0, 3)) < thr);
               if (ab && i == len / 2) break;
            end
            if (ab) begin
               cyc(1, 0, 1, 1);
               abort_f = 1;
            end else begin
               cyc(1, 1, 0, 0);
               if ($urandom_range(0, 15) == 0) cyc(0, 1, 0, 0);
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
